// File: rtl/aes_sbox_pipe.sv
`default_nettype none
// =============================================================================
// Module : aes_sbox_pipe
// Desc   : LANES-wide AES SubBytes / InvSubBytes with a STAGES-deep
//          valid/ready output pipeline and a delivered-word counter.
// Rev    : 1.0 - initial release
// =============================================================================
module aes_sbox_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_inv,
    output logic [8*LANES-1:0]   out_data,
    output logic [15:0]          done_cnt
);
    localparam int c_DW   = 8 * LANES;
    localparam int c_LAST = STAGES - 1;

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = f_xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] f_gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = f_gf_mul(s, s);
            r = f_gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] f_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] f_inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // Both directions share one field inverter; only the affine step moves.
    function automatic logic [7:0] f_sub_byte(input logic inv, input logic [7:0] x);
        logic [7:0] pre;
        logic [7:0] y;
        pre = inv ? f_inv_affine(x) : x;
        y   = f_gf_inv(pre);
        return inv ? y : f_affine(y);
    endfunction

    logic [c_DW-1:0]                w_sub;
    logic [STAGES-1:0]              r_vld;
    logic [STAGES-1:0]              r_inv;
    logic [STAGES-1:0][c_DW-1:0]    r_data;
    logic [STAGES:0]                w_free;
    logic [STAGES-1:0]              w_src_vld;
    logic [STAGES-1:0]              w_src_inv;
    logic [STAGES-1:0][c_DW-1:0]    w_src_data;
    logic [15:0]                    r_done_cnt;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_sub[8*i +: 8] = f_sub_byte(in_inv, in_data[8*i +: 8]);
        end
    endgenerate

    // Stage k may load when it is empty or its word leaves this cycle;
    // w_free[STAGES] stands for the consumer taking the last stage.
    always_comb begin
        w_free         = '0;
        w_free[STAGES] = out_ready;
        for (int k = c_LAST; k >= 0; k--) begin
            w_free[k] = ~r_vld[k] | w_free[k+1];
        end
    end

    always_comb begin
        w_src_vld     = '0;
        w_src_inv     = '0;
        w_src_data    = '0;
        w_src_vld[0]  = in_valid;
        w_src_inv[0]  = in_inv;
        w_src_data[0] = w_sub;
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k]  = r_vld[k-1];
            w_src_inv[k]  = r_inv[k-1];
            w_src_data[k] = r_data[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld      <= '0;
            r_inv      <= '0;
            r_data     <= '0;
            r_done_cnt <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_free[k]) begin
                    r_vld[k] <= w_src_vld[k];
                    // Payload only moves with a real word so idle outputs keep their value
                    if (w_src_vld[k]) begin
                        r_inv[k]  <= w_src_inv[k];
                        r_data[k] <= w_src_data[k];
                    end
                end
            end
            if (r_vld[c_LAST] && out_ready) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

    assign in_ready  = w_free[0];
    assign out_valid = r_vld[c_LAST];
    assign out_inv   = r_inv[c_LAST];
    assign out_data  = r_data[c_LAST];
    assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_pipe.sv
`default_nettype none
// =============================================================================
// Module : tb_aes_sbox_pipe
// Desc   : Directed bench for aes_sbox_pipe (STAGES=1 and STAGES=2 instances).
// Rev    : 1.0 - initial release
// =============================================================================
module tb_aes_sbox_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid1 = 1'b0, in_inv1 = 1'b0, out_ready1 = 1'b0;
    logic [31:0] in_data1 = '0;
    logic        in_ready1, out_valid1, out_inv1;
    logic [31:0] out_data1;
    logic [15:0] done_cnt1;

    logic        in_valid2 = 1'b0, in_inv2 = 1'b0, out_ready2 = 1'b0;
    logic [31:0] in_data2 = '0;
    logic        in_ready2, out_valid2, out_inv2;
    logic [31:0] out_data2;
    logic [15:0] done_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_sbox_pipe #(.LANES(4), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_inv(in_inv1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_inv(out_inv1),
        .out_data(out_data1), .done_cnt(done_cnt1)
    );

    aes_sbox_pipe #(.LANES(4), .STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_inv(in_inv2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_inv(out_inv2),
        .out_data(out_data2), .done_cnt(done_cnt2)
    );

    logic [7:0] fwd_tab [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] inv_tab [0:255];

    typedef struct {
        logic        inv;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [8];
    logic [31:0] stream_exp [256];
    logic        stream_inv [256];
    logic [31:0] stream_orig [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] map_word(input logic inv, input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            b = w[8*j +: 8];
            r[8*j +: 8] = inv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [31:0] seq_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        vecs[0] = '{1'b0, 32'h0001_53FF, 32'h637C_ED16};
        vecs[1] = '{1'b1, 32'h6300_7CFF, 32'h0052_017D};
        vecs[2] = '{1'b0, 32'h0000_0000, 32'h6363_6363};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h1616_1616};
        vecs[4] = '{1'b1, 32'h1616_1616, 32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 32'h1020_3040, 32'hCAB7_0409};
        vecs[6] = '{1'b1, 32'h5209_0000, 32'h4840_5252};
        vecs[7] = '{1'b0, 32'h0123_4567, 32'h7C26_6E85};

        // Reset state, both instances
        repeat (2) @(negedge clk);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
        chk("rst_out_data1",  out_data1, 32'd0);
        chk("rst_done_cnt1",  32'(done_cnt1), 32'd0);
        chk("rst_in_ready1",  32'(in_ready1), 32'd1);
        chk("rst_out_valid2", 32'(out_valid2), 32'd0);
        chk("rst_in_ready2",  32'(in_ready2), 32'd1);
        rst = 1'b0;

        // Single forward word, latency 1, counter after handshake
        @(negedge clk);
        in_valid1 = 1'b1; in_inv1 = 1'b0; in_data1 = 32'h0001_53FF; out_ready1 = 1'b1;
        @(negedge clk);
        chk("w1_out_valid", 32'(out_valid1), 32'd1);
        chk("w1_out_data",  out_data1, 32'h637C_ED16);
        chk("w1_out_inv",   32'(out_inv1), 32'd0);
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("w1_done_cnt",  32'(done_cnt1), 32'd1);
        chk("w1_idle_valid", 32'(out_valid1), 32'd0);
        chk("w1_idle_hold", out_data1, 32'h637C_ED16);

        // Directed vector table, streamed back-to-back
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("vec_valid", 32'(out_valid1), 32'd1);
                chk("vec_data",  out_data1, vecs[k-1].dout);
                chk("vec_inv",   32'(out_inv1), 32'(vecs[k-1].inv));
            end
            if (k < 8) begin
                chk("vec_in_ready", 32'(in_ready1), 32'd1);
                in_valid1 = 1'b1; in_inv1 = vecs[k].inv; in_data1 = vecs[k].din;
            end else begin
                in_valid1 = 1'b0;
            end
        end
        @(negedge clk);
        chk("vec_done_cnt", 32'(done_cnt1), 32'd9);

        // 256 back-to-back words: even forward, odd inverts the previous result
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) begin
                stream_inv[i]  = 1'b0;
                stream_orig[i] = seq_word(i);
                stream_exp[i]  = map_word(1'b0, stream_orig[i]);
            end else begin
                stream_inv[i]  = 1'b1;
                stream_orig[i] = stream_exp[i-1];
                stream_exp[i]  = map_word(1'b1, stream_orig[i]);
            end
        end
        for (int k = 0; k <= 256; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("bb_valid", 32'(out_valid1), 32'd1);
                chk("bb_data",  out_data1, stream_exp[k-1]);
                chk("bb_inv",   32'(out_inv1), 32'(stream_inv[k-1]));
                if (k % 2 == 0) chk("bb_roundtrip", out_data1, seq_word(k-2));
            end
            if (k < 256) begin
                in_valid1 = 1'b1; in_inv1 = stream_inv[k]; in_data1 = stream_orig[k];
            end else begin
                in_valid1 = 1'b0;
            end
        end
        @(negedge clk);
        chk("bb_done_cnt", 32'(done_cnt1), 32'd265);

        // STAGES=2 backpressure: two accepted, third refused, ordered drain
        @(negedge clk);
        out_ready2 = 1'b0;
        in_valid2 = 1'b1; in_inv2 = vecs[0].inv; in_data2 = vecs[0].din;
        @(negedge clk);
        chk("bp_lat_valid", 32'(out_valid2), 32'd0);
        chk("bp_ready_a",   32'(in_ready2), 32'd1);
        in_inv2 = vecs[1].inv; in_data2 = vecs[1].din;
        @(negedge clk);
        chk("bp_ready_full", 32'(in_ready2), 32'd0);
        chk("bp_valid_a",    32'(out_valid2), 32'd1);
        in_inv2 = vecs[2].inv; in_data2 = vecs[2].din;
        @(negedge clk);
        chk("bp_ready_stall", 32'(in_ready2), 32'd0);
        chk("bp_hold_data",   out_data2, vecs[0].dout);
        chk("bp_hold_inv",    32'(out_inv2), 32'(vecs[0].inv));
        out_ready2 = 1'b1;
        #1;
        chk("bp_ready_release", 32'(in_ready2), 32'd1);
        @(negedge clk);
        in_valid2 = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            chk("bp_drain_valid", 32'(out_valid2), 32'd1);
            chk("bp_drain_data",  out_data2, vecs[k].dout);
            chk("bp_drain_inv",   32'(out_inv2), 32'(vecs[k].inv));
            @(negedge clk);
        end
        chk("bp_empty_valid", 32'(out_valid2), 32'd0);
        chk("bp_done_cnt",    32'(done_cnt2), 32'd3);

        // Asynchronous reset with two words in flight
        out_ready2 = 1'b0;
        in_valid2 = 1'b1; in_inv2 = vecs[4].inv; in_data2 = vecs[4].din;
        @(negedge clk);
        in_inv2 = vecs[3].inv; in_data2 = vecs[3].din;
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("ar_full_valid", 32'(out_valid2), 32'd1);
        chk("ar_full_ready", 32'(in_ready2), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid_drop", 32'(out_valid2), 32'd0);
        chk("ar_cnt_drop",   32'(done_cnt2), 32'd0);
        chk("ar_data_clear", out_data2, 32'd0);
        chk("ar_ready",      32'(in_ready2), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready2 = 1'b1;
        in_valid2 = 1'b1; in_inv2 = vecs[5].inv; in_data2 = vecs[5].din;
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("ar_first_lat", 32'(out_valid2), 32'd0);
        @(negedge clk);
        chk("ar_first_valid", 32'(out_valid2), 32'd1);
        chk("ar_first_data",  out_data2, vecs[5].dout);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_no_stale", 32'(out_valid2), 32'd0);
        end
        chk("ar_done_cnt", 32'(done_cnt2), 32'd1);

        // Counter wrap: 65535 deliveries, then one more
        in_valid1 = 1'b1; in_inv1 = 1'b0; in_data1 = 32'h0; out_ready1 = 1'b1;
        repeat (65535) @(negedge clk);
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("wrap_ffff",  32'(done_cnt1), 32'h0000_FFFF);
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("wrap_zero",  32'(done_cnt1), 32'h0000_0000);
        chk("wrap_idle",  32'(out_valid1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
